// File: rtl/srt16_csa_otf_if.sv
// Bundles the operand and result buses of the SRT16 leaf cluster.
// The master side drives the operands; the slave side returns the results.
interface srt16_csa_otf_if;
  logic [9:0]  csa10_in_0, csa10_in_1, csa10_in_2;
  logic [9:0]  csa10_out_0, csa10_out_1;
  logic [37:0] csa38_in_0, csa38_in_1, csa38_in_2;
  logic [37:0] csa38_out_0, csa38_out_1;
  logic [31:0] otf_quotient, otf_quotientMinusOne;
  logic [4:0]  otf_selectedQuotientOH;
  logic [31:0] otf_out_quotient, otf_out_quotientMinusOne;

  modport master (
    output csa10_in_0, csa10_in_1, csa10_in_2,
    output csa38_in_0, csa38_in_1, csa38_in_2,
    output otf_quotient, otf_quotientMinusOne, otf_selectedQuotientOH,
    input  csa10_out_0, csa10_out_1, csa38_out_0, csa38_out_1,
    input  otf_out_quotient, otf_out_quotientMinusOne
  );

  modport slave (
    input  csa10_in_0, csa10_in_1, csa10_in_2,
    input  csa38_in_0, csa38_in_1, csa38_in_2,
    input  otf_quotient, otf_quotientMinusOne, otf_selectedQuotientOH,
    output csa10_out_0, csa10_out_1, csa38_out_0, csa38_out_1,
    output otf_out_quotient, otf_out_quotientMinusOne
  );
endinterface

// File: rtl/srt16_csa_otf.sv
// Combinational leaf cluster for the radix-16 SRT iteration: two 3:2
// carry-save adders and a radix-4 on-the-fly quotient converter.

module srt16_csa_lane (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic carry_o,
  output logic sum_o
);
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign sum_o   = a_i ^ b_i ^ c_i;
endmodule

module srt16_csa #(
  parameter int W = 10
) (
  input  logic [W-1:0] in_0_i,
  input  logic [W-1:0] in_1_i,
  input  logic [W-1:0] in_2_i,
  output logic [W-1:0] carry_o,
  output logic [W-1:0] sum_o
);
  // Carry is left unshifted; the caller applies the extra weight.
  for (genvar i = 0; i < W; i++) begin : g_lane
    srt16_csa_lane u_lane (
      .a_i     (in_0_i[i]),
      .b_i     (in_1_i[i]),
      .c_i     (in_2_i[i]),
      .carry_o (carry_o[i]),
      .sum_o   (sum_o[i])
    );
  end
endmodule

module srt16_otf (
  input  logic [31:0] q_i,
  input  logic [31:0] qm_i,
  input  logic [4:0]  oh_i,
  output logic [31:0] q_o,
  output logic [31:0] qm_o
);
  logic [31:0] q_sh, qm_sh;
  logic [4:0][31:0] q_term, qm_term;

  assign q_sh  = {q_i[29:0], 2'b00};
  assign qm_sh = {qm_i[29:0], 2'b00};

  // Select index k corresponds to digit k-2.
  assign q_term[0]  = qm_sh | 32'd2;
  assign q_term[1]  = qm_sh | 32'd3;
  assign q_term[2]  = q_sh;
  assign q_term[3]  = q_sh  | 32'd1;
  assign q_term[4]  = q_sh  | 32'd2;
  assign qm_term[0] = qm_sh | 32'd1;
  assign qm_term[1] = qm_sh | 32'd2;
  assign qm_term[2] = qm_sh | 32'd3;
  assign qm_term[3] = q_sh;
  assign qm_term[4] = q_sh  | 32'd1;

  // AND-OR mux: a non-one-hot select ORs the chosen terms together.
  always_comb begin
    q_o  = '0;
    qm_o = '0;
    for (int k = 0; k < 5; k++) begin
      q_o  = q_o  | ({32{oh_i[k]}} & q_term[k]);
      qm_o = qm_o | ({32{oh_i[k]}} & qm_term[k]);
    end
  end
endmodule

module srt16_csa_otf (
  input  logic             clock,
  input  logic             reset,
  srt16_csa_otf_if.slave   bus
);
  // Clock and reset exist only for integration uniformity.
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;

  srt16_csa #(.W(10)) u_csa10 (
    .in_0_i  (bus.csa10_in_0),
    .in_1_i  (bus.csa10_in_1),
    .in_2_i  (bus.csa10_in_2),
    .carry_o (bus.csa10_out_0),
    .sum_o   (bus.csa10_out_1)
  );

  srt16_csa #(.W(38)) u_csa38 (
    .in_0_i  (bus.csa38_in_0),
    .in_1_i  (bus.csa38_in_1),
    .in_2_i  (bus.csa38_in_2),
    .carry_o (bus.csa38_out_0),
    .sum_o   (bus.csa38_out_1)
  );

  srt16_otf u_otf (
    .q_i  (bus.otf_quotient),
    .qm_i (bus.otf_quotientMinusOne),
    .oh_i (bus.otf_selectedQuotientOH),
    .q_o  (bus.otf_out_quotient),
    .qm_o (bus.otf_out_quotientMinusOne)
  );
endmodule

// File: tb/tb_srt16_csa_otf.sv
// Self-checking bench for srt16_csa_otf: directed vectors plus randomized
// operands checked against an arithmetic model of CSA and OTF conversion.
module tb_srt16_csa_otf;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  srt16_csa_otf_if bus ();

  srt16_csa_otf dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Per-bit: carry = (ones count >= 2), sum = ones count odd.
  function automatic logic [37:0] m_carry(input logic [37:0] a, b, c);
    logic [37:0] r;
    for (int i = 0; i < 38; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  function automatic logic [37:0] m_sum(input logic [37:0] a, b, c);
    logic [37:0] r;
    for (int i = 0; i < 38; i++) r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) % 2) == 1;
    return r;
  endfunction

  // Digit d = k-2 appended to Q (d>=0) or borrowed from QM (d<0).
  function automatic void m_otf(input logic [31:0] q, qm, input logic [4:0] oh,
                                output logic [31:0] nq, output logic [31:0] nqm);
    longint d;
    longint unsigned vq, vqm;
    nq = '0;
    nqm = '0;
    for (int k = 0; k < 5; k++) begin
      if (oh[k]) begin
        d = k - 2;
        if (d >= 0) vq = longint'(q) * 4 + d;
        else        vq = longint'(qm) * 4 + (4 + d);
        if (d > 0)  vqm = longint'(q) * 4 + (d - 1);
        else        vqm = longint'(qm) * 4 + (3 + d);
        nq  = nq  | vq[31:0];
        nqm = nqm | vqm[31:0];
      end
    end
  endfunction

  task automatic drive_csa10(input logic [9:0] a, b, c);
    bus.csa10_in_0 = a; bus.csa10_in_1 = b; bus.csa10_in_2 = c;
  endtask

  task automatic drive_csa38(input logic [37:0] a, b, c);
    bus.csa38_in_0 = a; bus.csa38_in_1 = b; bus.csa38_in_2 = c;
  endtask

  task automatic drive_otf(input logic [31:0] q, qm, input logic [4:0] oh);
    bus.otf_quotient = q; bus.otf_quotientMinusOne = qm; bus.otf_selectedQuotientOH = oh;
  endtask

  task automatic test_csa10_basic;
    drive_csa10(10'h3FF, 10'h000, 10'h155);
    #1;
    tot_cnt++;
    if ({bus.csa10_out_0, bus.csa10_out_1} !== {10'h155, 10'h2AA})
      $display("FAIL csa10_basic: got %h/%h want 155/2aa", bus.csa10_out_0, bus.csa10_out_1);
    else pass_cnt++;
  endtask

  task automatic test_csa10_random;
    logic [9:0] a, b, c;
    logic [37:0] ec, es;
    int lhs, rhs;
    for (int n = 0; n < 40; n++) begin
      a = 10'($urandom); b = 10'($urandom); c = 10'($urandom);
      drive_csa10(a, b, c);
      #1;
      ec = m_carry({28'd0, a}, {28'd0, b}, {28'd0, c});
      es = m_sum({28'd0, a}, {28'd0, b}, {28'd0, c});
      lhs = (2 * int'(bus.csa10_out_0) + int'(bus.csa10_out_1)) % 2048;
      rhs = (int'(a) + int'(b) + int'(c)) % 2048;
      tot_cnt++;
      if (bus.csa10_out_0 !== ec[9:0] || bus.csa10_out_1 !== es[9:0] || lhs != rhs)
        $display("FAIL csa10_rand: in %h %h %h got %h/%h want %h/%h",
                 a, b, c, bus.csa10_out_0, bus.csa10_out_1, ec[9:0], es[9:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_csa38_extremes;
    logic [37:0] all1 = 38'h3F_FFFF_FFFF;
    drive_csa38(all1, all1, all1);
    #1;
    tot_cnt++;
    if (bus.csa38_out_0 !== all1 || bus.csa38_out_1 !== all1)
      $display("FAIL csa38_ones: got %h/%h want %h/%h", bus.csa38_out_0, bus.csa38_out_1, all1, all1);
    else pass_cnt++;
    drive_csa38(38'd1, 38'd1, 38'd0);
    #1;
    tot_cnt++;
    if (bus.csa38_out_0 !== 38'd1 || bus.csa38_out_1 !== 38'd0)
      $display("FAIL csa38_one_one: got %h/%h want 1/0", bus.csa38_out_0, bus.csa38_out_1);
    else pass_cnt++;
    drive_csa38(38'd0, 38'd0, 38'd0);
    #1;
    tot_cnt++;
    if (bus.csa38_out_0 !== 38'd0 || bus.csa38_out_1 !== 38'd0)
      $display("FAIL csa38_zero: got %h/%h want 0/0", bus.csa38_out_0, bus.csa38_out_1);
    else pass_cnt++;
  endtask

  task automatic test_csa38_random;
    logic [37:0] a, b, c;
    longint unsigned lhs, rhs;
    for (int n = 0; n < 40; n++) begin
      a = {6'($urandom), 32'($urandom)};
      b = {6'($urandom), 32'($urandom)};
      c = {6'($urandom), 32'($urandom)};
      drive_csa38(a, b, c);
      #1;
      lhs = (2 * longint'(bus.csa38_out_0) + longint'(bus.csa38_out_1)) % (64'd1 << 39);
      rhs = (longint'(a) + longint'(b) + longint'(c)) % (64'd1 << 39);
      tot_cnt++;
      if (bus.csa38_out_0 !== m_carry(a, b, c) || bus.csa38_out_1 !== m_sum(a, b, c) || lhs != rhs)
        $display("FAIL csa38_rand: in %h %h %h got %h/%h want %h/%h",
                 a, b, c, bus.csa38_out_0, bus.csa38_out_1, m_carry(a, b, c), m_sum(a, b, c));
      else pass_cnt++;
    end
  endtask

  task automatic test_otf_digits;
    logic [31:0] wq [5] = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
    logic [31:0] wqm[5] = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
    for (int k = 0; k < 5; k++) begin
      drive_otf(32'h5, 32'h4, 5'(1 << k));
      #1;
      tot_cnt++;
      if (bus.otf_out_quotient !== wq[k] || bus.otf_out_quotientMinusOne !== wqm[k])
        $display("FAIL otf_digit%0d: got %h/%h want %h/%h", k,
                 bus.otf_out_quotient, bus.otf_out_quotientMinusOne, wq[k], wqm[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_otf_trunc;
    drive_otf(32'hC000_0001, 32'hC000_0000, 5'b01000);
    #1;
    tot_cnt++;
    if (bus.otf_out_quotient !== 32'h5 || bus.otf_out_quotientMinusOne !== 32'h4)
      $display("FAIL otf_trunc: got %h/%h want 5/4", bus.otf_out_quotient, bus.otf_out_quotientMinusOne);
    else pass_cnt++;
  endtask

  task automatic test_otf_zero;
    for (int n = 0; n < 4; n++) begin
      drive_otf($urandom, $urandom, 5'b00000);
      #1;
      tot_cnt++;
      if (bus.otf_out_quotient !== 32'd0 || bus.otf_out_quotientMinusOne !== 32'd0)
        $display("FAIL otf_zero: got %h/%h want 0/0", bus.otf_out_quotient, bus.otf_out_quotientMinusOne);
      else pass_cnt++;
    end
  endtask

  // Random Q/QM with any 5-bit select, including non-one-hot.
  task automatic test_otf_random;
    logic [31:0] q, qm, eq, eqm;
    logic [4:0] oh;
    for (int n = 0; n < 60; n++) begin
      q = $urandom; qm = $urandom;
      oh = (n < 30) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
      drive_otf(q, qm, oh);
      #1;
      m_otf(q, qm, oh, eq, eqm);
      tot_cnt++;
      if (bus.otf_out_quotient !== eq || bus.otf_out_quotientMinusOne !== eqm)
        $display("FAIL otf_rand: q=%h qm=%h oh=%b got %h/%h want %h/%h", q, qm, oh,
                 bus.otf_out_quotient, bus.otf_out_quotientMinusOne, eq, eqm);
      else pass_cnt++;
    end
  endtask

  // Outputs follow inputs immediately while reset is held across edges.
  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_csa10(10'h3FF, 10'h000, 10'h155);
      drive_otf(32'h5, 32'h4, 5'(1 << k));
      #1;
      tot_cnt++;
      if ({bus.csa10_out_0, bus.csa10_out_1} !== {10'h155, 10'h2AA} ||
          bus.otf_out_quotient !== 32'h12 + 32'(k) || bus.otf_out_quotientMinusOne !== 32'h11 + 32'(k))
        $display("FAIL reset_follow%0d: got %h/%h %h/%h want 155/2aa %h/%h", k,
                 bus.csa10_out_0, bus.csa10_out_1, bus.otf_out_quotient,
                 bus.otf_out_quotientMinusOne, 32'h12 + 32'(k), 32'h11 + 32'(k));
      else pass_cnt++;
      @(posedge clock);
      #1;
      tot_cnt++;
      if (bus.otf_out_quotient !== 32'h12 + 32'(k) || bus.csa10_out_1 !== 10'h2AA)
        $display("FAIL reset_edge%0d: got %h/%h want %h/2aa", k,
                 bus.otf_out_quotient, bus.csa10_out_1, 32'h12 + 32'(k));
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    drive_csa10('0, '0, '0);
    drive_csa38('0, '0, '0);
    drive_otf('0, '0, 5'b00100);
    test_reset();
    test_csa10_basic();
    test_csa10_random();
    test_csa38_extremes();
    test_csa38_random();
    test_otf_digits();
    test_otf_trunc();
    test_otf_zero();
    test_otf_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
